regfile_sequencer: RTL and testbench

- Command-driven initiator for the 8-bit-data, 4-bit-address register file (ports wr, Rw, Din, R1, R2, OUT1, OUT2).
- Accepts single commands over a valid/ready interface and turns each one into correctly timed register-file accesses:
  - write one register;
  - read a register pair;
  - copy one register to another;
  - clear every register.
- Returns read data over a valid/ready response channel.
- Sits between the datapath control and the register file.

---
 rtl/regfile_sequencer.sv | 178 +++++++++++++++++
 tb/tb_regfile_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command sequencer for an 8-bit x 16 register file: turns write, read-pair,
// copy and clear commands into timed register-file accesses with a response channel.
module regfile_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_d1,
  output logic [DATA_W-1:0] rsp_d2,
  output logic              busy,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] rf_r1,
  output logic [ADDR_W-1:0] rf_r2,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;
  localparam logic [2:0] S_COPY_RD = 3'd5;
  localparam logic [2:0] S_COPY_WR = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic              live_q;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rf_wr_q, rf_wr_d;
  logic [ADDR_W-1:0] rf_rw_q, rf_rw_d;
  logic [DATA_W-1:0] rf_din_q, rf_din_d;
  logic [ADDR_W-1:0] rf_r1_q, rf_r1_d;
  logic [ADDR_W-1:0] rf_r2_q, rf_r2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_d1_q, rsp_d1_d;
  logic [DATA_W-1:0] rsp_d2_q, rsp_d2_d;

  // live_q keeps cmd_ready/busy low while in reset and until the first edge after it
  assign cmd_ready = live_q && (state_q == S_IDLE);
  assign busy      = live_q && (state_q != S_IDLE);
  assign rf_wr     = rf_wr_q;
  assign rf_rw     = rf_rw_q;
  assign rf_din    = rf_din_q;
  assign rf_r1     = rf_r1_q;
  assign rf_r2     = rf_r2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_d1    = rsp_d1_q;
  assign rsp_d2    = rsp_d2_q;

  // Next-state and next-output decode; outputs are set up one edge ahead of their state
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rf_wr_d     = 1'b0;
    rf_rw_d     = rf_rw_q;
    rf_din_d    = rf_din_q;
    rf_r1_d     = rf_r1_q;
    rf_r2_d     = rf_r2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d1_d    = rsp_d1_q;
    rsp_d2_d    = rsp_d2_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && live_q) begin
          b_d = cmd_b;
          case (cmd_op)
            2'b00: begin
              state_d  = S_WRITE;
              rf_wr_d  = 1'b1;
              rf_rw_d  = cmd_a;
              rf_din_d = cmd_data;
            end
            2'b01: begin
              state_d = S_READ;
              rf_r1_d = cmd_a;
              rf_r2_d = cmd_b;
            end
            2'b10: begin
              state_d  = S_CLEAR;
              cnt_d    = {ADDR_W{1'b0}};
              rf_wr_d  = 1'b1;
              rf_rw_d  = {ADDR_W{1'b0}};
              rf_din_d = {DATA_W{1'b0}};
            end
            default: begin
              state_d = S_COPY_RD;
              rf_r1_d = cmd_a;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE:   state_d = S_IDLE;
      S_READ: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_d1_d    = rf_out1;
        rsp_d2_d    = rf_out2;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + ONE_ADDR;
          rf_wr_d = 1'b1;
          rf_rw_d = cnt_q + ONE_ADDR;
        end
      end
      S_COPY_RD: begin
        // rf_din doubles as the holding register for the copied value
        state_d  = S_COPY_WR;
        rf_wr_d  = 1'b1;
        rf_rw_d  = b_q;
        rf_din_d = rf_out1;
      end
      S_COPY_WR: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset drops rf_wr and any pending response at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      b_q         <= {ADDR_W{1'b0}};
      cnt_q       <= {ADDR_W{1'b0}};
      rf_wr_q     <= 1'b0;
      rf_rw_q     <= {ADDR_W{1'b0}};
      rf_din_q    <= {DATA_W{1'b0}};
      rf_r1_q     <= {ADDR_W{1'b0}};
      rf_r2_q     <= {ADDR_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_d1_q    <= {DATA_W{1'b0}};
      rsp_d2_q    <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rf_wr_q     <= rf_wr_d;
      rf_rw_q     <= rf_rw_d;
      rf_din_q    <= rf_din_d;
      rf_r1_q     <= rf_r1_d;
      rf_r2_q     <= rf_r2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_d1_q    <= rsp_d1_d;
      rsp_d2_q    <= rsp_d2_d;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: a plain register-file model hangs off the rf_* ports and an
// array of expected register contents is updated per command.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_d1, rsp_d2;
  logic       busy;
  logic       rf_wr;
  logic [3:0] rf_rw, rf_r1, rf_r2;
  logic [7:0] rf_din, rf_out1, rf_out2;

  logic [7:0] rf_mem  [16];
  logic [7:0] exp_mem [16];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2),
    .busy(busy), .rf_wr(rf_wr), .rf_rw(rf_rw), .rf_din(rf_din),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  // Register file being driven: synchronous write, combinational reads
  always @(posedge clk) if (rf_wr) rf_mem[rf_rw] <= rf_din;
  assign rf_out1 = rf_mem[rf_r1];
  assign rf_out2 = rf_mem[rf_r2];

  // Wait (bounded) for cmd_ready, present the command for one accepting edge
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_write(input logic [3:0] a, input logic [7:0] d);
    issue(2'b00, a, 4'd0, d);
    total++;
    if (rf_wr !== 1'b1 || rf_rw !== a || rf_din !== d || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL write_pulse: wr=%b rw=%0d din=%h busy=%b rdy=%b required 1 %0d %h 1 0",
                      rf_wr, rf_rw, rf_din, busy, cmd_ready, a, d);
    end
    @(posedge clk); #1;
    total++;
    if (rf_wr !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL write_end: wr=%b rdy=%b required 0 1", rf_wr, cmd_ready);
    end
    exp_mem[a] = d;
  endtask

  task automatic test_read(input logic [3:0] a, input logic [3:0] b, input int hold);
    issue(2'b01, a, b, 8'd0);
    total++;
    if (rsp_valid !== 1'b0 || rf_wr !== 1'b0) begin
      bad++; $display("FAIL read_early: rsp_valid=%b wr=%b required 0 0", rsp_valid, rf_wr);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_d1 !== exp_mem[a] || rsp_d2 !== exp_mem[b]) begin
      bad++; $display("FAIL read_rsp(%0d,%0d): valid=%b d1=%h d2=%h required 1 %h %h",
                      a, b, rsp_valid, rsp_d1, rsp_d2, exp_mem[a], exp_mem[b]);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_d1 !== exp_mem[a] || rsp_d2 !== exp_mem[b] || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL rsp_hold: valid=%b d1=%h d2=%h rdy=%b required 1 %h %h 0",
                        rsp_valid, rsp_d1, rsp_d2, cmd_ready, exp_mem[a], exp_mem[b]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rsp_done: valid=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_copy(input logic [3:0] a, input logic [3:0] b);
    issue(2'b11, a, b, 8'd0);
    total++;
    if (rf_wr !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL copy_rd: wr=%b busy=%b required 0 1", rf_wr, busy);
    end
    @(posedge clk); #1;
    total++;
    if (rf_wr !== 1'b1 || rf_rw !== b || rf_din !== exp_mem[a]) begin
      bad++; $display("FAIL copy_wr: wr=%b rw=%0d din=%h required 1 %0d %h",
                      rf_wr, rf_rw, rf_din, b, exp_mem[a]);
    end
    @(posedge clk); #1;
    total++;
    if (rf_wr !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL copy_end: wr=%b rdy=%b required 0 1", rf_wr, cmd_ready);
    end
    exp_mem[b] = exp_mem[a];
  endtask

  task automatic test_clear();
    int wr_cycles = 0;
    int addr_errs = 0;
    issue(2'b10, 4'd0, 4'd0, 8'd0);
    for (int i = 0; i < 20 && rf_wr === 1'b1; i++) begin
      if (rf_rw !== 4'(i) || rf_din !== 8'd0) addr_errs++;
      wr_cycles++;
      @(posedge clk); #1;
    end
    total++;
    if (wr_cycles != 16 || addr_errs != 0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL clear_sweep: cycles=%0d addr_errs=%0d rdy=%b required 16 0 1",
                      wr_cycles, addr_errs, cmd_ready);
    end
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b0 || rf_wr !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: rdy=%b wr=%b rsp_valid=%b busy=%b required 0 0 0 0",
                      cmd_ready, rf_wr, rsp_valid, busy);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge: rdy=%b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rf_wr !== 1'b0) begin
      bad++; $display("FAIL ready_after_reset: rdy=%b busy=%b wr=%b required 1 0 0",
                      cmd_ready, busy, rf_wr);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    test_write(4'd4, 8'h44);
    test_write(4'd8, 8'(8'h80 | $urandom_range(1, 127)));
    test_write(4'd5, 8'(8'h01 | $urandom_range(0, 255)));
    issue(2'b10, 4'd0, 4'd0, 8'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    total++;
    if (rf_wr !== 1'b1 || rf_rw !== 4'd5) begin
      bad++; $display("FAIL clear_6th_cycle: wr=%b rw=%0d required 1 5", rf_wr, rf_rw);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rf_wr !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset: wr=%b rdy=%b rsp_valid=%b required 0 0 0",
                      rf_wr, cmd_ready, rsp_valid);
    end
    for (int i = 0; i < 5; i++) exp_mem[i] = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_read(4'd4, 4'd8, 0);
    test_read(4'd5, 4'd15, 0);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: test_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        4, 5, 6:    test_read(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              int'($urandom_range(0, 3)));
        7, 8:       test_copy(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        default:    test_clear();
      endcase
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) test_write(4'(i), 8'($urandom_range(1, 255)));
    test_write(4'd0, 8'd2);
    test_write(4'd1, 8'd4);
    test_write(4'd2, 8'd6);
    test_write(4'd3, 8'd8);
    test_read(4'd0, 4'd1, 0);
    test_read(4'd2, 4'd3, 0);
    test_read(4'd1, 4'd3, 5);
    test_copy(4'd3, 4'd7);
    test_read(4'd7, 4'd3, 0);
    test_write(4'd5, 8'h5A);
    test_copy(4'd5, 4'd5);
    test_read(4'd5, 4'd7, 0);
    test_write(4'd15, 8'hFF);
    test_clear();
    test_read(4'd15, 4'd0, 0);
    test_random(60);
    test_reset_mid_clear();
    test_random(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
